// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and constants for the sprite (OAM) DMA bus-sharing controller.
// Bus direction encodings and the 3-bit DMA state encoding.
package oam_dma_ctrl_pkg;

  localparam logic RW_R = 1'b1;
  localparam logic RW_W = 1'b0;

  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DEST_ADDR_DEF    = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_bus_mux.sv
// Combinational bus owner select: DMA-driven address/data/rw when dma_own, else CPU.
// Zero latency; no flow control.
module dma_bus_mux (
  input  logic        dma_own,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_d,
  input  logic        dma_rw,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_rw
);

  assign bus_a  = dma_own ? dma_a  : cpu_a;
  assign bus_d  = dma_own ? dma_d  : cpu_d;
  assign bus_rw = dma_own ? dma_rw : cpu_rw;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: halts the CPU and copies one page to DEST_ADDR as read/write pairs.
// Optional macro KNES_DMA_ALIGN_EN inserts one ALIGN cycle when HALT lands on an odd cycle.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEF,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_d_in,
  output logic        halt,
  output logic        dma_own,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_rw,
  output logic        busy
);

  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  cnt;
  logic [7:0]  data_hold;
  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        dma_rw;

`ifdef KNES_DMA_ALIGN_EN
  logic cyc_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_odd <= 1'b0;
    else        cyc_odd <= ~cyc_odd;
  end
`endif

  // halt/dma_own/busy are updated alongside state so they are true registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DMA_IDLE;
      halt      <= 1'b0;
      dma_own   <= 1'b0;
      busy      <= 1'b0;
      page      <= 8'h00;
      cnt       <= 8'h00;
      data_hold <= 8'h00;
    end else begin
      case (state)
        DMA_IDLE: begin
          if (cpu_a == DMA_REG_ADDR && cpu_rw == RW_W) begin
            page    <= cpu_d;
            cnt     <= 8'h00;
            state   <= DMA_HALT;
            halt    <= 1'b1;
            dma_own <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DMA_HALT: begin
`ifdef KNES_DMA_ALIGN_EN
          state <= cyc_odd ? DMA_ALIGN : DMA_READ;
`else
          state <= DMA_READ;
`endif
        end
`ifdef KNES_DMA_ALIGN_EN
        DMA_ALIGN: state <= DMA_READ;
`endif
        DMA_READ: begin
          data_hold <= bus_d_in;
          state     <= DMA_WRITE;
        end
        DMA_WRITE: begin
          if (cnt == LAST_CNT) begin
            state   <= DMA_IDLE;
            halt    <= 1'b0;
            dma_own <= 1'b0;
            busy    <= 1'b0;
          end else begin
            cnt   <= cnt + 8'd1;
            state <= DMA_READ;
          end
        end
        default: begin
          state   <= DMA_IDLE;
          halt    <= 1'b0;
          dma_own <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // HALT/ALIGN present a discarded dummy read of the trigger register.
  always_comb begin
    dma_a  = DMA_REG_ADDR;
    dma_rw = RW_R;
    dma_d  = data_hold;
    case (state)
      DMA_READ:  dma_a = {page, cnt};
      DMA_WRITE: begin
        dma_a  = DEST_ADDR;
        dma_rw = RW_W;
      end
      default: ;
    endcase
  end

  dma_bus_mux u_mux (
    .dma_own (dma_own),
    .cpu_a   (cpu_a),
    .cpu_d   (cpu_d),
    .cpu_rw  (cpu_rw),
    .dma_a   (dma_a),
    .dma_d   (dma_d),
    .dma_rw  (dma_rw),
    .bus_a   (bus_a),
    .bus_d   (bus_d),
    .bus_rw  (bus_rw)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: full-page copies, pass-through, async reset abort,
// and a single-byte instance. Memory model returns address low byte XOR 8'hA5.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_a = 16'h8000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_d_in;

  logic        halt, dma_own, bus_rw, busy;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        halt1, own1, bus_rw1, busy1;
  logic [15:0] bus_a1;
  logic [7:0]  bus_d1;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  assign bus_d_in = bus_a[7:0] ^ 8'hA5;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  oam_dma_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_rw(cpu_rw),
    .bus_d_in(bus_d_in), .halt(halt), .dma_own(dma_own), .bus_a(bus_a),
    .bus_d(bus_d), .bus_rw(bus_rw), .busy(busy)
  );

  oam_dma_ctrl #(.XFER_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_rw(cpu_rw),
    .bus_d_in(bus_d_in), .halt(halt1), .dma_own(own1), .bus_a(bus_a1),
    .bus_d(bus_d1), .bus_rw(bus_rw1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int align_extra();
    int e = 0;
`ifdef KNES_DMA_ALIGN_EN
    e = edge_cnt % 2;
`endif
    return e;
  endfunction

  task automatic trigger(input logic [7:0] pg);
    @(negedge clk);
    cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_d = pg;
    @(posedge clk);
    #1;
    cpu_a = 16'h8000; cpu_rw = 1'b1; cpu_d = 8'h00;
  endtask

  // Full-length copy on the main instance, checking every bus cycle.
  task automatic do_xfer(input logic [7:0] pg, input string tag);
    int hcnt = 0, nerr = 0, nwr = 0, ext = 0, k;
    logic [15:0] ea;
    logic        erw;
    logic [7:0]  byte_i;
    trigger(pg);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 0) ext = align_extra();
      if (!halt) break;
      hcnt++;
      if (c < 1 + ext) begin
        ea = 16'h4014; erw = 1'b1;
      end else begin
        k = c - 1 - ext;
        byte_i = 8'(k / 2);
        if (k % 2 == 0) begin
          ea = {pg, byte_i}; erw = 1'b1;
        end else begin
          ea = 16'h2004; erw = 1'b0; nwr++;
          if (bus_d !== (byte_i ^ 8'hA5)) nerr++;
        end
      end
      if (bus_a !== ea || bus_rw !== erw || dma_own !== 1'b1 || busy !== 1'b1) nerr++;
    end
    chk({tag, "_halt_len"}, hcnt, 513 + ext);
    chk({tag, "_seq_err"}, nerr, 0);
    chk({tag, "_writes"}, nwr, 256);
    chk({tag, "_own_drop"}, dma_own, 1'b0);
    chk({tag, "_busy_drop"}, busy, 1'b0);
    chk({tag, "_pass_a"}, bus_a, 16'h8000);
  endtask

  initial begin
    int hcnt1, e1, ext, k, found;

    // Reset state
    #12;
    chk("rst_halt", halt, 1'b0);
    chk("rst_own", dma_own, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pass_a", bus_a, 16'h8000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: page 02
    do_xfer(8'h02, "t1");

    // Test 3: read of trigger address, write to neighbour
    @(negedge clk);
    cpu_a = 16'h4014; cpu_rw = 1'b1; cpu_d = 8'h33;
    repeat (3) @(negedge clk);
    chk("t3_rd_busy", busy, 1'b0);
    chk("t3_rd_a", bus_a, 16'h4014);
    chk("t3_rd_rw", bus_rw, 1'b1);
    cpu_a = 16'h4015; cpu_rw = 1'b0; cpu_d = 8'h5A;
    #1;
    chk("t3_wr_d", bus_d, 8'h5A);
    chk("t3_wr_rw", bus_rw, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_wr_busy", busy, 1'b0);
    chk("t3_wr_halt", halt, 1'b0);
    chk("t3_wr_a", bus_a, 16'h4015);
    cpu_a = 16'h8000; cpu_rw = 1'b1; cpu_d = 8'h00;

    // Test 4: page 07 pattern
    do_xfer(8'h07, "t4");

    // Test 5: async reset at byte 100, then restart
    trigger(8'h03);
    found = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus_a == 16'h0364) begin found = 1; break; end
    end
    chk("t5_reach_100", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_halt", halt, 1'b0);
    chk("t5_async_own", dma_own, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_pass", bus_a, 16'h8000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_xfer(8'h03, "t5");

    // Test 6: single-byte instance, page FF
    trigger(8'hFF);
    hcnt1 = 0; e1 = 0; ext = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 0) ext = align_extra();
      if (!halt) break;
      if (halt1) begin
        hcnt1++;
        k = c - 1 - ext;
        if (c < 1 + ext) begin
          if (bus_a1 !== 16'h4014 || bus_rw1 !== 1'b1) e1++;
        end else if (k == 0) begin
          if (bus_a1 !== 16'hFF00 || bus_rw1 !== 1'b1) e1++;
        end else if (k == 1) begin
          if (bus_a1 !== 16'h2004 || bus_rw1 !== 1'b0 || bus_d1 !== 8'hA5) e1++;
        end else begin
          e1++;
        end
      end
    end
    chk("t6_halt_len", hcnt1, 3 + ext);
    chk("t6_seq_err", e1, 0);
    chk("t6_own_drop", own1, 1'b0);
    chk("t6_busy_drop", busy1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
